// File: rtl/btb_cert_update_queue.sv
// Retire-side FIFO that feeds certain-update writes to every BTB way, holding its head while fetch1 writes speculatively.
// Optional BTB_CERT_COALESCE_EN merges a push into the youngest entry when the PC matches.
module btb_cert_update_queue #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          rt_br_valid_i,
  input  logic [63:0]   rt_br_pc_i,
  input  logic          rt_br_dir_i,
  input  logic [63:0]   rt_br_tar_i,
  output logic          rt_br_ready_o,
  input  logic          btb_we_spec_i,
  output logic          btb_we_cert_o,
  output logic [63:0]   btb_brpc_cert_o,
  output logic          btb_brdir_cert_o,
  output logic [63:0]   btb_brtar_cert_o,
  output logic [AW:0]   q_count_o,
  output logic [15:0]   stall_cnt_o
);

  // Handshake: an entry is accepted on any edge where rt_br_valid_i && rt_br_ready_o;
  // the head is consumed on any edge where btb_we_cert_o is high.
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   pc_mem  [DEPTH];
  logic          dir_mem [DEPTH];
  logic [63:0]   tar_mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   stall_cnt;
  logic          push;
  logic          pop;
  logic          coalesce;
  logic          alloc;

  assign rt_br_ready_o = (count != FULL);
  assign push          = rt_br_valid_i && rt_br_ready_o;
  assign btb_we_cert_o = (count != '0) && !btb_we_spec_i;
  assign pop           = btb_we_cert_o;

`ifdef BTB_CERT_COALESCE_EN
  logic [AW-1:0] young_ptr;
  assign young_ptr = wr_ptr - AW'(1);
  // A youngest entry that is leaving this cycle cannot absorb the update.
  assign coalesce  = push && (count != '0) && (rt_br_pc_i == pc_mem[young_ptr])
                     && !((count == (AW+1)'(1)) && pop);
`else
  assign coalesce  = 1'b0;
`endif

  assign alloc = push && !coalesce;

  assign btb_brpc_cert_o  = pc_mem[rd_ptr];
  assign btb_brdir_cert_o = dir_mem[rd_ptr];
  assign btb_brtar_cert_o = tar_mem[rd_ptr];
  assign q_count_o        = count;
  assign stall_cnt_o      = stall_cnt;

  // Entry storage carries no reset; contents are meaningless while count is 0.
  always_ff @(posedge clock) begin
    if (alloc) begin
      pc_mem[wr_ptr]  <= rt_br_pc_i;
      dir_mem[wr_ptr] <= rt_br_dir_i;
      tar_mem[wr_ptr] <= rt_br_tar_i;
    end
`ifdef BTB_CERT_COALESCE_EN
    else if (coalesce) begin
      dir_mem[young_ptr] <= rt_br_dir_i;
      tar_mem[young_ptr] <= rt_br_tar_i;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (alloc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({alloc, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (btb_we_spec_i && (count != '0) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_btb_cert_update_queue.sv
// Directed bench for btb_cert_update_queue: a vector table for single-cycle behaviour plus
// hand-written sequences for wrap-around, coalescing and asynchronous reset.
module tb_btb_cert_update_queue;

  logic        clock;
  logic        reset_n;
  logic        rt_br_valid_i;
  logic [63:0] rt_br_pc_i;
  logic        rt_br_dir_i;
  logic [63:0] rt_br_tar_i;
  logic        rt_br_ready_o;
  logic        btb_we_spec_i;
  logic        btb_we_cert_o;
  logic [63:0] btb_brpc_cert_o;
  logic        btb_brdir_cert_o;
  logic [63:0] btb_brtar_cert_o;
  logic [3:0]  q_count_o;
  logic [15:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];

  typedef struct {
    logic        valid;
    logic [63:0] pc;
    logic        dir;
    logic [63:0] tar;
    logic        spec;
    logic        e_ready;
    logic        e_we;
    logic [63:0] e_pc;
    logic        e_dir;
    logic [63:0] e_tar;
    logic [3:0]  e_count;
    logic [15:0] e_stall;
  } vec_t;

  vec_t vecs[$];

  btb_cert_update_queue #(.DEPTH(8), .AW(3)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .rt_br_valid_i    (rt_br_valid_i),
    .rt_br_pc_i       (rt_br_pc_i),
    .rt_br_dir_i      (rt_br_dir_i),
    .rt_br_tar_i      (rt_br_tar_i),
    .rt_br_ready_o    (rt_br_ready_o),
    .btb_we_spec_i    (btb_we_spec_i),
    .btb_we_cert_o    (btb_we_cert_o),
    .btb_brpc_cert_o  (btb_brpc_cert_o),
    .btb_brdir_cert_o (btb_brdir_cert_o),
    .btb_brtar_cert_o (btb_brtar_cert_o),
    .q_count_o        (q_count_o),
    .stall_cnt_o      (stall_cnt_o)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic valid, input logic [63:0] pc, input logic dir,
                         input logic [63:0] tar, input logic spec, input logic e_ready,
                         input logic e_we, input logic [63:0] e_pc, input logic e_dir,
                         input logic [63:0] e_tar, input logic [3:0] e_count,
                         input logic [15:0] e_stall);
    vec_t v;
    v.valid = valid; v.pc = pc; v.dir = dir; v.tar = tar; v.spec = spec;
    v.e_ready = e_ready; v.e_we = e_we; v.e_pc = e_pc; v.e_dir = e_dir;
    v.e_tar = e_tar; v.e_count = e_count; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  // driver: inputs change at the falling edge, so the next rising edge consumes them
  task automatic drive(input logic valid, input logic [63:0] pc, input logic dir,
                       input logic [63:0] tar, input logic spec);
    @(negedge clock);
    rt_br_valid_i = valid;
    rt_br_pc_i    = pc;
    rt_br_dir_i   = dir;
    rt_br_tar_i   = tar;
    btb_we_spec_i = spec;
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    rt_br_valid_i = 1'b0;
    rt_br_pc_i    = '0;
    rt_br_dir_i   = 1'b0;
    rt_br_tar_i   = '0;
    btb_we_spec_i = 1'b0;

    // basic push then pop
    add_vec(1, 64'h1000, 1, 64'h2000, 0,  1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0,                1, 1, 64'h1000, 1, 64'h2000, 1, 0);
    add_vec(0, 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 0);
    // blocked head for three cycles
    add_vec(1, 64'h1000, 1, 64'h2000, 0,  1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 1,                1, 0, 64'h1000, 1, 64'h2000, 1, 0);
    add_vec(0, 0, 0, 0, 1,                1, 0, 64'h1000, 1, 64'h2000, 1, 1);
    add_vec(0, 0, 0, 0, 1,                1, 0, 64'h1000, 1, 64'h2000, 1, 2);
    add_vec(0, 0, 0, 0, 0,                1, 1, 64'h1000, 1, 64'h2000, 1, 3);
    add_vec(0, 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 3);
    // fill to full while blocked
    for (int i = 0; i < 8; i++)
      add_vec(1, 64'h100 + 64'(4*i), i[0], 64'h200 + 64'(4*i), 1,
              1, 0, 64'h100, 0, 64'h200, 4'(i), 16'(3 + ((i > 0) ? i - 1 : 0)));
    add_vec(1, 64'h999, 1, 64'h999, 1,    0, 0, 64'h100, 0, 64'h200, 8, 10);
    // drain in order
    for (int j = 0; j < 8; j++)
      add_vec(0, 0, 0, 0, 0, (j != 0), 1, 64'h100 + 64'(4*j), j[0],
              64'h200 + 64'(4*j), 4'(8 - j), 11);
    add_vec(0, 0, 0, 0, 0,                1, 0, 0, 0, 0, 0, 11);

    #3;
    chk("reset_ready", 64'(rt_br_ready_o), 1);
    chk("reset_we",    64'(btb_we_cert_o), 0);
    chk("reset_count", 64'(q_count_o), 0);
    chk("reset_stall", 64'(stall_cnt_o), 0);
    #9 reset_n = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      drive(vecs[k].valid, vecs[k].pc, vecs[k].dir, vecs[k].tar, vecs[k].spec);
      chk($sformatf("v%0d_ready", k), 64'(rt_br_ready_o), 64'(vecs[k].e_ready));
      chk($sformatf("v%0d_we", k),    64'(btb_we_cert_o), 64'(vecs[k].e_we));
      chk($sformatf("v%0d_count", k), 64'(q_count_o),     64'(vecs[k].e_count));
      chk($sformatf("v%0d_stall", k), 64'(stall_cnt_o),   64'(vecs[k].e_stall));
      if (vecs[k].e_count != 0) begin
        chk($sformatf("v%0d_pc", k),  btb_brpc_cert_o,        vecs[k].e_pc);
        chk($sformatf("v%0d_dir", k), 64'(btb_brdir_cert_o),  64'(vecs[k].e_dir));
        chk($sformatf("v%0d_tar", k), btb_brtar_cert_o,       vecs[k].e_tar);
      end
    end

    // simultaneous push and pop with pointer wrap
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'h300 + 64'(4*i), i[0], 64'h400 + 64'(4*i), 1);
      exp_q.push_back(64'h300 + 64'(4*i));
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h330 + 64'(4*i), 1, 64'h430 + 64'(4*i), 0);
      chk("pp_count", 64'(q_count_o), 3);
      chk("pp_we",    64'(btb_we_cert_o), 1);
      chk("pp_pc",    btb_brpc_cert_o, exp_q[0]);
      void'(exp_q.pop_front());
      exp_q.push_back(64'h330 + 64'(4*i));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("pp_drain_we", 64'(btb_we_cert_o), 1);
      chk("pp_drain_pc", btb_brpc_cert_o, exp_q[0]);
      void'(exp_q.pop_front());
    end
    drive(0, 0, 0, 0, 0);
    chk("pp_empty", 64'(q_count_o), 0);
    chk("pp_stall", 64'(stall_cnt_o), 13);

    // same-PC back-to-back retire
    drive(1, 64'h40, 0, 64'h80, 1);
    drive(1, 64'h40, 1, 64'hC0, 1);
    drive(0, 0, 0, 0, 0);
`ifdef BTB_CERT_COALESCE_EN
    chk("co_count", 64'(q_count_o), 1);
    chk("co_dir",   64'(btb_brdir_cert_o), 1);
    chk("co_tar",   btb_brtar_cert_o, 64'hC0);
`else
    chk("co_count", 64'(q_count_o), 2);
    chk("co_dir0",  64'(btb_brdir_cert_o), 0);
    chk("co_tar0",  btb_brtar_cert_o, 64'h80);
    drive(0, 0, 0, 0, 0);
    chk("co_dir1",  64'(btb_brdir_cert_o), 1);
    chk("co_tar1",  btb_brtar_cert_o, 64'hC0);
`endif
    chk("co_we",    64'(btb_we_cert_o), 1);
    chk("co_stall", 64'(stall_cnt_o), 14);
    drive(0, 0, 0, 0, 0);
    chk("co_empty", 64'(q_count_o), 0);

    // asynchronous reset mid-operation
    for (int i = 0; i < 5; i++)
      drive(1, 64'h500 + 64'(4*i), 0, 64'h600, 1);
    drive(0, 0, 0, 0, 0);
    chk("rst_pre_count", 64'(q_count_o), 5);
    chk("rst_pre_we",    64'(btb_we_cert_o), 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_we",    64'(btb_we_cert_o), 0);
    chk("rst_count", 64'(q_count_o), 0);
    chk("rst_ready", 64'(rt_br_ready_o), 1);
    chk("rst_stall", 64'(stall_cnt_o), 0);
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0);
    chk("post_rst_count", 64'(q_count_o), 0);
    chk("post_rst_we",    64'(btb_we_cert_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
